// File: rtl/demux_4x4_buffered.sv
// 1-to-4 registered demultiplexer with a one-entry valid/ready holding register
// per output channel, so a stalled consumer never blocks the other channels.
module demux_4x4_buffered #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data_0,
    output logic [WIDTH-1:0] out_data_1,
    output logic [WIDTH-1:0] out_data_2,
    output logic [WIDTH-1:0] out_data_3,
    output logic             busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [4];
    chan_state_t      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [3:0]       full;
    logic             acc;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            full[k] = (state_q[k] == FULL);
        end
    end

    // A full channel can still take a word in the cycle its consumer drains it.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];
    assign acc      = in_valid & in_ready;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (acc && (in_sel == 2'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if (full[k] && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    assign out_valid  = full;
    assign busy       = |full;
    assign out_data_0 = data_q[0];
    assign out_data_1 = data_q[1];
    assign out_data_2 = data_q[2];
    assign out_data_3 = data_q[3];

endmodule

// File: tb/tb_demux_4x4_buffered.sv
// Randomized and directed bench for demux_4x4_buffered against a per-channel
// occupancy/data model built from the transfer rules.
module tb_demux_4x4_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [3:0] out_data_0, out_data_1, out_data_2, out_data_3;
    logic       busy;
    logic [3:0] od [4];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_full;
    logic [3:0] m_data [4];
    logic       last_acc;
    int         acc_cnt;

    always #5 clk = ~clk;

    demux_4x4_buffered #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_0 (out_data_0),
        .out_data_1 (out_data_1),
        .out_data_2 (out_data_2),
        .out_data_3 (out_data_3),
        .busy       (busy)
    );

    assign od[0] = out_data_0;
    assign od[1] = out_data_1;
    assign od[2] = out_data_2;
    assign od[3] = out_data_3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", {28'd0, out_valid}, {28'd0, m_full});
        check("busy", {31'd0, busy}, {31'd0, (m_full != 4'b0000)});
        for (int k = 0; k < 4; k++) begin
            if (m_full[k]) check($sformatf("out_data_%0d", k), {28'd0, od[k]}, {28'd0, m_data[k]});
        end
    endtask

    // One cycle: drive, check against model, advance model, cross the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [3:0] d, input logic [3:0] ordy);
        logic exp_rdy;
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = !m_full[s] || ordy[s];
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check_outputs();
        last_acc = 1'b0;
        if (r) begin
            m_full = 4'b0000;
            for (int k = 0; k < 4; k++) m_data[k] = 4'h0;
        end else begin
            for (int k = 0; k < 4; k++) if (m_full[k] && ordy[k]) m_full[k] = 1'b0;
            if (v && exp_rdy) begin
                m_full[s] = 1'b1;
                m_data[s] = d;
                last_acc  = 1'b1;
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 4; k++) check($sformatf("rst_data_%0d", k), {28'd0, od[k]}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            in_valid = 1'b0;
            out_ready = 4'b0000;
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic       v, hold;
        logic [1:0] s;
        logic [3:0] d, ordy;

        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;
        m_full = 4'b0000;
        for (int k = 0; k < 4; k++) m_data[k] = 4'h0;
        acc_cnt = 0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        check_reset_state();

        // Routing with all consumers stalled
        step(1'b0, 1'b1, 2'd0, 4'hA, 4'h0);
        step(1'b0, 1'b1, 2'd1, 4'h5, 4'h0);
        step(1'b0, 1'b1, 2'd2, 4'hC, 4'h0);
        step(1'b0, 1'b1, 2'd3, 4'h3, 4'h0);
        check_outputs();

        // Backpressure on channel 2, then release
        step(1'b0, 1'b1, 2'd2, 4'h7, 4'h0);
        step(1'b0, 1'b1, 2'd2, 4'h7, 4'h0);
        step(1'b0, 1'b1, 2'd2, 4'h7, 4'b0100);
        check_outputs();

        // Reset while channels are full, with a transfer attempted
        step(1'b1, 1'b1, 2'd1, 4'hF, 4'b1010);
        check_reset_state();
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);

        // Pass-through throughput
        acc_cnt = 0;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 2'(i % 4), 4'(i), 4'hF);
        check("throughput_accepts", acc_cnt, 32'd16);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

        // Channel 0 stalled full, other channels keep flowing
        step(1'b0, 1'b1, 2'd0, 4'hE, 4'h0);
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'(1 + i % 3), 4'($urandom), 4'b1110);
        check("nonblock_accepts", acc_cnt, 32'd12);
        check("nonblock_ch0", {28'd0, out_data_0}, 32'hE);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

        // Simultaneous drain and fill on channel 1
        step(1'b0, 1'b1, 2'd1, 4'h9, 4'h0);
        step(1'b0, 1'b1, 2'd1, 4'h4, 4'b0010);
        check("dfill_valid1", {31'd0, out_valid[1]}, 32'd1);
        check("dfill_data1", {28'd0, out_data_1}, 32'h4);

        // Random traffic; producer holds its word while stalled
        hold = 1'b0; v = 1'b0; s = 2'd0; d = 4'h0;
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 49) == 0);
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom);
                d = 4'($urandom);
            end
            ordy = 4'($urandom);
            step(r, v, s, d, ordy);
            hold = v && !last_acc && !r;
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
